ntp_fetch_unit: RTL and testbench

//  Instruction-fetch end of the stall interface. Owns the program counter, drives the

---
 rtl/ntp_isa_pkg.sv | 21 ++
 rtl/ntp_pc_reg.sv | 33 +++
 rtl/ntp_fetch_unit.sv | 107 ++++++++++
 tb/tb_ntp_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ntp_isa_pkg.sv
// Opcode constants and fetch FSM state type shared by the fetch unit.
package ntp_isa_pkg;

  localparam logic [2:0]  OP_JMP_MSB3 = 3'b111;
  localparam logic [4:0]  OP_LD       = 5'b10100;
  localparam logic [4:0]  OP_HLT      = 5'b10001;
  localparam logic [23:0] NOP_WORD    = 24'h000000;

  typedef enum logic [2:0] {
    RUN,
    JMP1,
    JMP2,
    LDW,
    HALT
  } fetch_state_e;

  function automatic logic [4:0] ins_op(input logic [23:0] ins_word);
    return ins_word[23:19];
  endfunction

endpackage

// File: rtl/ntp_pc_reg.sv
// Program counter with freeze, load and increment; wraps modulo 2**ADDR_W.
module ntp_pc_reg #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_freeze,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_stall,
  output logic [ADDR_W-1:0] o_pc
);

  localparam logic [ADDR_W-1:0] One = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_pc;

  // Freeze beats a redirect, which beats a plain stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
    end else if (i_freeze) begin
      r_pc <= r_pc;
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (!i_stall) begin
      r_pc <= r_pc + One;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/ntp_fetch_unit.sv
// Fetch end of the stall interface: PC, NOP insertion and jump/load/halt tracking.
// Optional STALL_CNT_EN adds a saturating stall-cycle counter output.
module ntp_fetch_unit #(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [23:0] NOP_WORD = ntp_isa_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              Stall_pm,
  input  logic [23:0]       pm_data,
  input  logic              jmp_taken,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [23:0]       ins,
  output logic              halted,
`ifdef STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              seq_err
);

  import ntp_isa_pkg::*;

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [4:0]   w_op;
  logic         w_in_jmp;
  logic         w_freeze;
  logic         w_load;
  logic         r_halted;
  logic         r_seq_err;

  assign ins      = Stall_pm ? NOP_WORD : pm_data;
  assign w_op     = ins_op(ins);
  assign w_in_jmp = (r_state == JMP1) || (r_state == JMP2);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      RUN: begin
        if (Stall) begin
          if (w_op[4:2] == OP_JMP_MSB3) begin
            w_state_next = JMP1;
          end else if (w_op == OP_LD) begin
            w_state_next = LDW;
          end else if (w_op == OP_HLT) begin
            w_state_next = HALT;
          end
        end
      end
      JMP1:    w_state_next = JMP2;
      JMP2:    w_state_next = RUN;
      LDW:     w_state_next = RUN;
      HALT:    w_state_next = HALT;
      default: w_state_next = RUN;
    endcase
  end

  // PC must not move on the very edge that enters HALT.
  assign w_freeze = (r_state == HALT) || (w_state_next == HALT);
  assign w_load   = jmp_taken && w_in_jmp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_halted  <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_halted <= (w_state_next == HALT);
      if (jmp_taken && !w_in_jmp) begin
        r_seq_err <= 1'b1;
      end
    end
  end

  ntp_pc_reg #(
    .ADDR_W (ADDR_W)
  ) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .i_freeze    (w_freeze),
    .i_load      (w_load),
    .i_load_addr (jmp_addr),
    .i_stall     (Stall),
    .o_pc        (pm_addr)
  );

  assign halted  = r_halted;
  assign seq_err = r_seq_err;

`ifdef STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if ((Stall || (r_state != RUN)) && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ntp_fetch_unit.sv
// Bench for ntp_fetch_unit: vector table, hand-written halt/reset sequences, random run.
module tb_ntp_fetch_unit;

  localparam logic [23:0] W_NOP = 24'h000000;
  localparam logic [23:0] W_JMP = 24'hE00000;
  localparam logic [23:0] W_LD  = 24'hA00000;
  localparam logic [23:0] W_HLT = 24'h880000;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        Stall     = 1'b0;
  logic        Stall_pm  = 1'b0;
  logic [23:0] pm_data   = '0;
  logic        jmp_taken = 1'b0;
  logic [7:0]  jmp_addr  = '0;
  logic [7:0]  pm_addr;
  logic [23:0] ins;
  logic        halted;
  logic        seq_err;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  ntp_fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .Stall     (Stall),
    .Stall_pm  (Stall_pm),
    .pm_data   (pm_data),
    .jmp_taken (jmp_taken),
    .jmp_addr  (jmp_addr),
    .pm_addr   (pm_addr),
    .ins       (ins),
    .halted    (halted),
`ifdef STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: PC as an integer, a jump-acceptance window, load-wait and halt flags.
  int m_pc;
  int m_jwin;
  bit m_ldw;
  bit m_halt;
  bit m_seq;
  int m_cnt;

  typedef struct {
    bit          first;
    logic [7:0]  start;
    logic [23:0] pd;
    logic        spm;
    logic        st;
    logic        jt;
    logic [7:0]  ja;
    logic [7:0]  e_addr;
    logic [23:0] e_ins;
    logic        e_seq;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_jwin = 0; m_ldw = 0; m_halt = 0; m_seq = 0; m_cnt = 0;
  endtask

  // Drive one cycle's inputs at the falling edge and compare against the model.
  task automatic drive_check(input logic [23:0] pd, input logic spm, input logic st,
                             input logic jt, input logic [7:0] ja);
    logic [23:0] e_ins;
    @(negedge clk);
    pm_data = pd; Stall_pm = spm; Stall = st; jmp_taken = jt; jmp_addr = ja;
    #1;
    e_ins = spm ? 24'h000000 : pd;
    chk("pm_addr", 32'(pm_addr), 32'(m_pc));
    chk("ins", 32'(ins), 32'(e_ins));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("seq_err", 32'(seq_err), 32'(m_seq));
`ifdef STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
  endtask

  // Apply the spec's rules for the current inputs, then cross the rising edge.
  task automatic advance();
    logic [23:0] cur;
    logic [4:0]  op;
    bit          jwin;
    bit          go_halt;
    cur     = Stall_pm ? 24'h000000 : pm_data;
    op      = cur[23:19];
    jwin    = (m_jwin > 0);
    go_halt = !m_halt && !jwin && !m_ldw && Stall && (op == 5'b10001);
    if (jmp_taken && !jwin) m_seq = 1;
    if (Stall || m_halt || jwin || m_ldw) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    if (!(m_halt || go_halt)) begin
      if (jmp_taken && jwin) m_pc = int'(jmp_addr);
      else if (!Stall) m_pc = (m_pc + 1) % 256;
    end
    if (m_halt) begin
    end else if (jwin) begin
      m_jwin--;
    end else if (m_ldw) begin
      m_ldw = 0;
    end else if (Stall) begin
      if (op[4:2] == 3'b111) m_jwin = 2;
      else if (op == 5'b10100) m_ldw = 1;
      else if (op == 5'b10001) m_halt = 1;
    end
    @(posedge clk);
  endtask

  // Called right after drive_check: pulse reset between edges and check the cleared outputs.
  task automatic async_reset();
    pm_data = '0; Stall_pm = 0; Stall = 0; jmp_taken = 0; jmp_addr = '0;
    reset = 1'b0;
    #1;
    chk("rst_pm_addr", 32'(pm_addr), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_seq_err", 32'(seq_err), 32'h0);
`ifdef STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
`endif
    reset = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic do_reset();
    drive_check(W_NOP, 0, 0, 0, 8'h00);
    async_reset();
    advance();
  endtask

  task automatic goto_pc(input logic [7:0] target);
    for (int i = 0; i < 300 && m_pc != int'(target); i++) begin
      drive_check(W_NOP, 0, 0, 0, 8'h00);
      advance();
    end
    chk("goto_pc_reached", 32'(m_pc), 32'(target));
  endtask

  task automatic add(input bit first, input logic [7:0] start, input logic [23:0] pd,
                     input logic spm, input logic st, input logic jt, input logic [7:0] ja,
                     input logic [7:0] e_addr, input logic [23:0] e_ins, input logic e_seq);
    vec_t v;
    v.first = first; v.start = start; v.pd = pd; v.spm = spm; v.st = st; v.jt = jt;
    v.ja = ja; v.e_addr = e_addr; v.e_ins = e_ins; v.e_seq = e_seq;
    tbl.push_back(v);
  endtask

  initial begin
    logic [4:0]  rop;
    logic [23:0] rpd;
    int          r;

    model_reset();
    // jmp_taken in RUN: PC still increments, seq_err sticks
    add(1, 8'h05, W_NOP, 0, 0, 1, 8'h77, 8'h05, W_NOP, 0);
    add(0, 8'h00, W_NOP, 0, 0, 0, 8'h00, 8'h06, W_NOP, 1);
    add(0, 8'h00, W_NOP, 0, 0, 0, 8'h00, 8'h07, W_NOP, 1);
    // straight-line wrap
    add(1, 8'hFE, W_NOP, 0, 0, 0, 8'h00, 8'hFE, W_NOP, 0);
    add(0, 8'h00, W_NOP, 0, 0, 0, 8'h00, 8'hFF, W_NOP, 0);
    add(0, 8'h00, W_NOP, 0, 0, 0, 8'h00, 8'h00, W_NOP, 0);
    add(0, 8'h00, W_NOP, 0, 0, 0, 8'h00, 8'h01, W_NOP, 0);
    // jump redirected in JMP1
    add(1, 8'h10, W_JMP,      0, 1, 0, 8'h00, 8'h10, W_JMP,      0);
    add(0, 8'h00, 24'h123456, 1, 1, 1, 8'h40, 8'h10, W_NOP,      0);
    add(0, 8'h00, 24'h654321, 1, 0, 0, 8'h00, 8'h40, W_NOP,      0);
    add(0, 8'h00, 24'h0ABCDE, 0, 0, 0, 8'h00, 8'h41, 24'h0ABCDE, 0);
    add(0, 8'h00, W_NOP,      0, 0, 0, 8'h00, 8'h42, W_NOP,      0);
    // load: single hold cycle
    add(1, 8'h20, W_LD,       0, 1, 0, 8'h00, 8'h20, W_LD,       0);
    add(0, 8'h00, 24'h111111, 1, 0, 0, 8'h00, 8'h20, W_NOP,      0);
    add(0, 8'h00, 24'h222222, 0, 0, 0, 8'h00, 8'h21, 24'h222222, 0);
    add(0, 8'h00, 24'h333333, 0, 0, 0, 8'h00, 8'h22, 24'h333333, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].first) begin
        do_reset();
        goto_pc(tbl[i].start);
      end
      drive_check(tbl[i].pd, tbl[i].spm, tbl[i].st, tbl[i].jt, tbl[i].ja);
      chk($sformatf("tbl%0d_addr", i), 32'(pm_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_ins", i), 32'(ins), 32'(tbl[i].e_ins));
      chk($sformatf("tbl%0d_seq", i), 32'(seq_err), 32'(tbl[i].e_seq));
      advance();
    end

    // Halt at 0x30: frozen for 100 clocks despite Stall and jmp_taken.
    do_reset();
    goto_pc(8'h30);
    drive_check(W_HLT, 0, 1, 0, 8'h00);
    chk("hlt_halted_same_cycle", 32'(halted), 32'h0);
    advance();
    for (int i = 0; i < 100; i++) begin
      drive_check(24'($urandom), 1'($urandom), 1'($urandom), (i == 0) ? 1'b1 : 1'($urandom),
                  8'($urandom));
      chk("hlt_addr_frozen", 32'(pm_addr), 32'h30);
      chk("hlt_halted", 32'(halted), 32'h1);
      if (i > 0) chk("hlt_seq_err", 32'(seq_err), 32'h1);
      advance();
    end
`ifdef STALL_CNT_EN
    drive_check(W_NOP, 0, 0, 0, 8'h00);
    chk("hlt_stall_cnt", 32'(stall_cnt), 32'd101);
    advance();
`endif

    // Async reset mid-cycle from PC 0x5A while halted with seq_err set.
    do_reset();
    goto_pc(8'h59);
    drive_check(W_NOP, 0, 0, 1, 8'h99);
    advance();
    drive_check(W_HLT, 0, 1, 0, 8'h00);
    advance();
    drive_check(W_NOP, 0, 0, 0, 8'h00);
    chk("pre_rst_addr", 32'(pm_addr), 32'h5A);
    chk("pre_rst_halted", 32'(halted), 32'h1);
    chk("pre_rst_seq", 32'(seq_err), 32'h1);
    async_reset();
    advance();

    // Randomised run against the model, with periodic resets to escape HALT.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 249) do_reset();
      r = int'($urandom_range(0, 99));
      if (r < 14)      rop = {3'b111, 2'($urandom)};
      else if (r < 26) rop = 5'b10100;
      else if (r < 28) rop = 5'b10001;
      else             rop = 5'($urandom);
      rpd = {rop, 19'($urandom)};
      drive_check(rpd, ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) < 35),
                  ($urandom_range(0, 99) < 15), 8'($urandom));
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
